shake_length_tracker: RTL and testbench



---
 rtl/shake_length_tracker_pkg.sv | 23 ++
 rtl/shake_length_tracker_if.sv | 38 +++
 rtl/shake_length_tracker_sat_down_counter.sv | 25 ++
 rtl/shake_length_tracker.sv | 117 +++++++++++
 tb/tb_shake_length_tracker.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/shake_length_tracker_pkg.sv
// Shared types and rate constants for the SHAKE absorb length tracker.
package shake_pkg;

    localparam int RATE128_WORDS = 21;
    localparam int RATE256_WORDS = 17;

    typedef enum logic {
        SHAKE128 = 1'b0,
        SHAKE256 = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAD,
        ST_DONE
    } tracker_state_t;

    function automatic int rate_words(mode_t m);
        return (m == SHAKE256) ? RATE256_WORDS : RATE128_WORDS;
    endfunction

endpackage

// File: rtl/shake_length_tracker_if.sv
// Load/advance handshake and status bus between the word stream and the tracker.
interface shake_length_tracker_if #(
    parameter int WIDTH          = 32,
    parameter int W              = 64,
    parameter int MAX_RATE_WORDS = 21
);
    localparam int IW = $clog2(MAX_RATE_WORDS);
    localparam int VW = $clog2(W + 1);

    logic             mode;
    logic [WIDTH-1:0] len_in;
    logic             len_valid;
    logic             len_ready;
    logic             advance;
    logic             abort;
    logic [WIDTH-1:0] remaining;
    logic [IW-1:0]    word_idx;
    logic [VW-1:0]    valid_bits;
    logic             last_word;
    logic             last_block;
    logic             block_end;
    logic             pad_phase;
    logic [WIDTH-1:0] block_count;
    logic             done;

    modport master (
        output mode, len_in, len_valid, advance, abort,
        input  len_ready, remaining, word_idx, valid_bits, last_word,
               last_block, block_end, pad_phase, block_count, done
    );

    modport slave (
        input  mode, len_in, len_valid, advance, abort,
        output len_ready, remaining, word_idx, valid_bits, last_word,
               last_block, block_end, pad_phase, block_count, done
    );

endinterface

// File: rtl/shake_length_tracker_sat_down_counter.sv
// Remaining-bits register: load, clear, and decrement by STEP that floors at zero.
module sat_down_counter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value
);
    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

    always_ff @(posedge clk) begin
        if (rst || clr)
            value <= '0;
        else if (load)
            value <= load_val;
        else if (dec)
            value <= (value < STEP_V) ? '0 : value - STEP_V;
    end

endmodule

// File: rtl/shake_length_tracker.sv
// Tracks message bits left in one SHAKE absorb pass and sequences the padding words/blocks.
module shake_length_tracker
    import shake_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int W              = 64,
    parameter int MAX_RATE_WORDS = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    shake_length_tracker_if.slave bus
);
    localparam int IW = $clog2(MAX_RATE_WORDS);
    localparam int VW = $clog2(W + 1);
    localparam int CW = (WIDTH > 11) ? WIDTH : 11;
    localparam logic [WIDTH-1:0] W_V = WIDTH'(W);

    tracker_state_t   state, state_d;
    mode_t            mode_q, mode_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] bc_q, bc_d;
    logic [WIDTH-1:0] rem;
    logic             cnt_load, cnt_dec, cnt_clr;
    logic             at_end, rem_le_w, rem_lt_w;
    logic [CW-1:0]    rem_cw, span_cw;

    sat_down_counter #(.WIDTH(WIDTH), .STEP(W)) u_rem (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (bus.len_in),
        .value    (rem)
    );

    assign at_end   = (idx_q == IW'(rate_words(mode_q) - 1));
    assign rem_le_w = (rem <= W_V);
    assign rem_lt_w = (rem < W_V);

    // Bits still fitting in the current block; strict compare keeps an exact fill off last_block
    // since the pad byte then spills into a fresh block.
    assign rem_cw  = CW'(rem);
    assign span_cw = CW'(rate_words(mode_q) - int'(idx_q)) * CW'(W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            mode_q <= SHAKE128;
            idx_q  <= '0;
            bc_q   <= '0;
        end else begin
            state  <= state_d;
            mode_q <= mode_d;
            idx_q  <= idx_d;
            bc_q   <= bc_d;
        end
    end

    always_comb begin
        state_d  = state;
        mode_d   = mode_q;
        idx_d    = idx_q;
        bc_d     = bc_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_clr  = 1'b0;
        if (bus.abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            bc_d    = '0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: if (bus.len_valid) begin
                    mode_d   = mode_t'(bus.mode);
                    idx_d    = '0;
                    bc_d     = '0;
                    cnt_load = 1'b1;
                    state_d  = (bus.len_in == '0) ? ST_PAD : ST_RUN;
                end
                ST_RUN: if (bus.advance) begin
                    cnt_dec = 1'b1;
                    idx_d   = at_end ? '0 : idx_q + IW'(1);
                    if (at_end)
                        bc_d = bc_q + WIDTH'(1);
                    // A short final word at block end has room for the pad byte.
                    if (rem_le_w)
                        state_d = (at_end && rem_lt_w) ? ST_DONE : ST_PAD;
                end
                ST_PAD: if (bus.advance) begin
                    if (at_end) begin
                        idx_d   = '0;
                        bc_d    = bc_q + WIDTH'(1);
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.len_ready   = (state == ST_IDLE);
    assign bus.remaining   = rem;
    assign bus.word_idx    = idx_q;
    assign bus.block_count = bc_q;
    assign bus.valid_bits  = (state != ST_RUN) ? '0 : (rem_le_w ? VW'(rem) : VW'(W));
    assign bus.last_word   = (state == ST_RUN) && rem_le_w;
    assign bus.last_block  = (state == ST_RUN) ? (rem_cw < span_cw) : (state == ST_PAD);
    assign bus.block_end   = ((state == ST_RUN) || (state == ST_PAD)) && at_end;
    assign bus.pad_phase   = (state == ST_PAD);
    assign bus.done        = (state == ST_DONE);

endmodule

// File: tb/tb_shake_length_tracker.sv
// Scoreboard bench: a message-level model predicts every cycle's outputs and each done pulse.
module tb_shake_length_tracker;

    typedef struct packed {
        logic        len_ready;
        logic [31:0] remaining;
        logic [4:0]  word_idx;
        logic [6:0]  valid_bits;
        logic        last_word;
        logic        last_block;
        logic        block_end;
        logic        pad_phase;
        logic [31:0] block_count;
        logic        done;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    shake_length_tracker_if #(.WIDTH(32), .W(64), .MAX_RATE_WORDS(21)) bus ();

    shake_length_tracker #(.WIDTH(32), .W(64), .MAX_RATE_WORDS(21)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    snap_t exp_q[$];
    int    done_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    // Model: a message of L bits at rate R words always occupies blocks = L/(R*64)+1
    // blocks (the pad byte must fit), i.e. blocks*R advances; words past ceil(L/64) are padding.
    int     phase = 0;  // 0 idle, 1 absorbing, 2 done
    longint L;
    int     R, k, n, blocks, total, bc_idle = 0;

    function automatic snap_t model_snap();
        snap_t  s;
        longint rem;
        s = '0;
        case (phase)
            0: begin
                s.len_ready   = 1'b1;
                s.block_count = 32'(bc_idle);
            end
            1: begin
                rem = L - longint'(k) * 64;
                if (rem < 0) rem = 0;
                s.remaining   = 32'(rem);
                s.word_idx    = 5'(k % R);
                s.block_count = 32'(k / R);
                s.block_end   = ((k % R) == R - 1);
                if (k < n) begin
                    s.valid_bits = 7'((rem > 64) ? 64 : rem);
                    s.last_word  = (rem <= 64);
                    s.last_block = ((k / R) == blocks - 1);
                end else begin
                    s.pad_phase  = 1'b1;
                    s.last_block = 1'b1;
                end
            end
            default: begin
                s.done        = 1'b1;
                s.block_count = 32'(blocks);
            end
        endcase
        return s;
    endfunction

    task automatic model_step(input bit r, input bit a, input bit lv,
                              input logic [31:0] len, input bit md, input bit adv);
        if (r || a) begin
            phase   = 0;
            bc_idle = 0;
        end else begin
            case (phase)
                0: if (lv) begin
                    L      = longint'(len);
                    R      = md ? 17 : 21;
                    k      = 0;
                    n      = int'((L + 63) / 64);
                    blocks = int'(L / (R * 64)) + 1;
                    total  = blocks * R;
                    phase  = 1;
                end
                1: if (adv) begin
                    k++;
                    if (k == total) begin
                        phase = 2;
                        done_q.push_back(blocks);
                    end
                end
                default: begin
                    phase   = 0;
                    bc_idle = blocks;
                end
            endcase
        end
    endtask

    task automatic step(input bit r, input bit a, input bit lv,
                        input logic [31:0] len, input bit md, input bit adv);
        rst           = r;
        bus.abort     = a;
        bus.len_valid = lv;
        bus.len_in    = len;
        bus.mode      = md;
        bus.advance   = adv;
        model_step(r, a, lv, len, md, adv);
        @(posedge clk);
        exp_q.push_back(model_snap());
        #1;
    endtask

    task automatic load(input logic [31:0] len, input bit md);
        step(0, 0, 1, len, md, 0);
    endtask

    // Advances with junk on the ignored inputs.
    task automatic adv_n(input int cnt);
        repeat (cnt) step(0, 0, 0, $urandom, 1'($urandom), 1);
    endtask

    task automatic idle_n(input int cnt);
        repeat (cnt) step(0, 0, 0, 32'd0, 1'b0, 0);
    endtask

    always @(negedge clk) begin
        snap_t e, a;
        int    eb;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{bus.len_ready, bus.remaining, bus.word_idx, bus.valid_bits, bus.last_word,
                  bus.last_block, bus.block_end, bus.pad_phase, bus.block_count, bus.done};
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t actual=%h required=%h", $time, a, e);
            end
        end
        if (bus.done === 1'b1) begin
            n_chk++;
            if (done_q.size() == 0) begin
                n_fail++;
                $display("FAIL done_pulse t=%0t actual=done required=no_done", $time);
            end else begin
                eb = done_q.pop_front();
                if (bus.block_count !== 32'(eb)) begin
                    n_fail++;
                    $display("FAIL done_block_count t=%0t actual=%0d required=%0d",
                             $time, bus.block_count, eb);
                end
            end
        end
    end

    initial begin
        bus.mode = 1'b0; bus.len_in = '0; bus.len_valid = 1'b0;
        bus.advance = 1'b0; bus.abort = 1'b0;

        step(1, 0, 0, 32'd0, 0, 0);
        step(1, 1, 1, 32'd64, 0, 1);
        idle_n(1);

        load(32'd64, 0);    adv_n(21); idle_n(2);
        load(32'd1088, 1);  adv_n(34); idle_n(2);
        load(32'd1080, 1);  adv_n(17); idle_n(2);
        load(32'd0, 0);     adv_n(21); idle_n(2);

        load(32'd640, 0);   adv_n(3);  step(0, 1, 0, 32'd0, 0, 1); idle_n(2);
        load(32'd640, 0);   adv_n(3);  step(1, 0, 0, 32'd0, 0, 1); idle_n(2);

        load(32'd200, 0);   adv_n(1);
        step(0, 0, 1, 32'd8, 1, 0);
        step(0, 0, 1, 32'd8, 1, 1);
        step(0, 0, 0, 32'd8, 0, 1);
        adv_n(18);
        idle_n(2);

        for (int t = 0; t < 40; t++) begin
            load(32'($urandom_range(0, 420) * 8), 1'($urandom));
            for (int c = 0; c < 400 && phase != 0; c++)
                step(($urandom % 300) == 0, ($urandom % 80) == 0, 1'($urandom),
                     $urandom, 1'($urandom), ($urandom % 4) != 0);
            idle_n($urandom_range(0, 2));
        end
        idle_n(3);

        n_chk++;
        if (done_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_missing actual=%0d_pending required=0", done_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
